// File: rtl/vector_mem_responder_pkg.sv
// Shared types and constants for the 3-lane vector memory responder.
// Word width depends on VMEM_PARITY_EN (one extra even-parity bit per word).
package vmem_pkg;
    localparam int LANES  = 3;
    localparam int DATA_W = 18;
    localparam int ADDR_W = 10;
`ifdef VMEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;
    typedef logic [ADDR_W-1:0]            lane_addr_t;
    typedef enum logic [2:0] {IDLE, ACC0, ACC1, ACC2, DONE} vmem_state_t;

    function automatic logic in_range(lane_addr_t a, int unsigned depth);
        return 32'(a) < depth;
    endfunction
endpackage

// File: rtl/vector_mem_responder_if.sv
// MEM-stage request/response bundle between the datapath (master) and the responder (slave).
import vmem_pkg::*;

interface vmem_if;
    logic       MemReqM;
    logic       MemWriteM;
    lane_addr_t A1M, A2M, A3M;
    lane_vec_t  writeDataM;
    lane_vec_t  RDE;
    logic       RdValid;
    logic       MemStall;
    logic       ParityErr;

    modport master (output MemReqM, MemWriteM, A1M, A2M, A3M, writeDataM,
                    input  RDE, RdValid, MemStall, ParityErr);
    modport slave  (input  MemReqM, MemWriteM, A1M, A2M, A3M, writeDataM,
                    output RDE, RdValid, MemStall, ParityErr);
endinterface

// File: rtl/vector_mem_responder_spram_sync.sv
// Single-port synchronous RAM: write at the edge, registered read (1-cycle latency).
module spram_sync #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/vector_mem_responder.sv
// Serialises a 3-lane vector access onto one single-port RAM, stalling the pipeline meanwhile.
// Optional even-parity protection and sticky ParityErr under VMEM_PARITY_EN.
import vmem_pkg::*;

module vector_mem_responder #(
    parameter int DEPTH = 1024
) (
    input  logic   CLK,
    input  logic   RST,
    vmem_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    vmem_state_t                        state, state_nx;
    logic                               wr_q;
    logic [LANES-1:0][ADDR_W-1:0]       addr_q;
    lane_vec_t                          wdata_q;
    logic [LANES-2:0][DATA_W-1:0]       cap_q;
    logic [LANES-1:0]                   ok;
    logic                               issue;
    logic [1:0]                         lane, cap_lane;
    logic                               ram_we;
    logic [AW-1:0]                      ram_addr;
    logic [WORD_W-1:0]                  ram_wdata, ram_rdata;
    logic [DATA_W-1:0]                  cap_word;

    always_comb begin
        for (int i = 0; i < LANES; i++) ok[i] = in_range(addr_q[i], DEPTH);
    end

    always_comb begin
        state_nx     = state;
        issue        = 1'b0;
        lane         = 2'd0;
        cap_lane     = 2'd0;
        bus.MemStall = 1'b0;
        case (state)
            IDLE: begin
                bus.MemStall = bus.MemReqM;
                if (bus.MemReqM) state_nx = ACC0;
            end
            ACC0: begin issue = 1'b1; lane = 2'd0; bus.MemStall = 1'b1; state_nx = ACC1; end
            ACC1: begin issue = 1'b1; lane = 2'd1; cap_lane = 2'd0; bus.MemStall = 1'b1; state_nx = ACC2; end
            ACC2: begin issue = 1'b1; lane = 2'd2; cap_lane = 2'd1; bus.MemStall = 1'b1; state_nx = DONE; end
            DONE: begin cap_lane = 2'd2; state_nx = IDLE; end
            default: state_nx = IDLE;
        endcase
    end

    // Out-of-range lanes never touch the RAM; their read words are forced to zero.
    assign ram_we   = issue && wr_q && ok[lane];
    assign ram_addr = addr_q[lane][AW-1:0];
`ifdef VMEM_PARITY_EN
    assign ram_wdata = {^wdata_q[lane], wdata_q[lane]};
`else
    assign ram_wdata = wdata_q[lane];
`endif
    assign cap_word = ok[cap_lane] ? ram_rdata[DATA_W-1:0] : '0;

    spram_sync #(.WIDTH(WORD_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk  (CLK),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cap_q       <= '0;
            bus.RDE     <= '0;
            bus.RdValid <= 1'b0;
        end else begin
            state       <= state_nx;
            bus.RdValid <= 1'b0;
            if (state == IDLE && bus.MemReqM) begin
                wr_q    <= bus.MemWriteM;
                addr_q  <= {bus.A3M, bus.A2M, bus.A1M};
                wdata_q <= bus.writeDataM;
            end
            if (state == ACC1) cap_q[0] <= cap_word;
            if (state == ACC2) cap_q[1] <= cap_word;
            if (state == DONE && !wr_q) begin
                bus.RDE     <= {cap_word, cap_q};
                bus.RdValid <= 1'b1;
            end
        end
    end

`ifdef VMEM_PARITY_EN
    logic [1:0] err_q;
    logic       rd_bad;
    assign rd_bad = ok[cap_lane] && (^ram_rdata);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q         <= '0;
            bus.ParityErr <= 1'b0;
        end else begin
            if (state == ACC1) err_q[0] <= rd_bad;
            if (state == ACC2) err_q[1] <= rd_bad;
            if (state == DONE && !wr_q)
                bus.ParityErr <= bus.ParityErr | err_q[0] | err_q[1] | rd_bad;
        end
    end
`else
    assign bus.ParityErr = 1'b0;
`endif
endmodule
